// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the core's IF/MEM requesters, the SRAM port arbiter and the external SRAM.
// slave: the arbiter's view; master: the core plus SRAM side.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                inst_req;
  logic [ADDR_W-1:0]   inst_addr;
  logic [DATA_W-1:0]   inst_rdata;
  logic                inst_ok;
  logic                inst_stall;

  logic                data_req;
  logic [DATA_W/8-1:0] data_wen;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic [DATA_W-1:0]   data_rdata;
  logic                data_ok;
  logic                data_stall;

  logic                sram_en;
  logic [DATA_W/8-1:0] sram_wen;
  logic [ADDR_W-1:0]   sram_addr;
  logic [DATA_W-1:0]   sram_wdata;
  logic [DATA_W-1:0]   sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wen, data_addr, data_wdata,
    input  sram_rdata,
    output inst_rdata, inst_ok, inst_stall,
    output data_rdata, data_ok, data_stall,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wen, data_addr, data_wdata,
    output sram_rdata,
    input  inst_rdata, inst_ok, inst_stall,
    input  data_rdata, data_ok, data_stall,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between instruction fetch and data access: issue/response per access,
// data priority with forced alternation. Optional macro KSEG_ADDR_MAP_EN enables kseg0/1 -> physical mapping.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  sram_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    D_ACC,
    D_RSP,
    I_ACC,
    I_RSP
  } state_t;

  state_t state, state_n;

  logic                sram_en_q;
  logic [DATA_W/8-1:0] sram_wen_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [DATA_W-1:0]   sram_wdata_q;

  logic                inst_ok_c;
  logic                data_ok_c;

  function automatic logic [ADDR_W-1:0] phys_addr(input logic [ADDR_W-1:0] a);
`ifdef KSEG_ADDR_MAP_EN
    return a[ADDR_W-1] ? {3'b000, a[ADDR_W-4:0]} : a;
`else
    return a;
`endif
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // A served requester is never re-granted from RSP: its req is still high there by protocol.
  always_comb begin
    state_n   = state;
    inst_ok_c = 1'b0;
    data_ok_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.data_req)      state_n = D_ACC;
        else if (bus.inst_req) state_n = I_ACC;
      end
      D_ACC: state_n = D_RSP;
      I_ACC: state_n = I_RSP;
      D_RSP: begin
        data_ok_c = 1'b1;
        state_n   = bus.inst_req ? I_ACC : IDLE;
      end
      I_RSP: begin
        inst_ok_c = 1'b1;
        state_n   = bus.data_req ? D_ACC : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sram_en_q    <= 1'b0;
      sram_wen_q   <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      sram_en_q    <= 1'b0;
      sram_wen_q   <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if (state_n == D_ACC) begin
        sram_en_q    <= 1'b1;
        sram_wen_q   <= bus.data_wen;
        sram_addr_q  <= phys_addr(bus.data_addr);
        sram_wdata_q <= bus.data_wdata;
      end else if (state_n == I_ACC) begin
        sram_en_q    <= 1'b1;
        sram_addr_q  <= phys_addr(bus.inst_addr);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conflict_cnt <= '0;
    end else if (state == IDLE && bus.inst_req && bus.data_req && conflict_cnt != '1) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  assign bus.sram_en    = sram_en_q;
  assign bus.sram_wen   = sram_wen_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;

  assign bus.inst_ok    = inst_ok_c;
  assign bus.data_ok    = data_ok_c;
  assign bus.inst_rdata = inst_ok_c ? bus.sram_rdata : '0;
  assign bus.data_rdata = data_ok_c ? bus.sram_rdata : '0;
  assign bus.inst_stall = bus.inst_req & ~inst_ok_c;
  assign bus.data_stall = bus.data_req & ~data_ok_c;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized requesters
// checked every cycle against a transaction-schedule reference model.
module tb_sram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_sat ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .conflict_cnt(cnt16)
  );

  // Narrow-counter copy sees identical stimulus; only its counter is checked.
  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .bus(bus_sat), .conflict_cnt(cnt2)
  );

  assign bus_sat.inst_req   = bus.inst_req;
  assign bus_sat.inst_addr  = bus.inst_addr;
  assign bus_sat.data_req   = bus.data_req;
  assign bus_sat.data_wen   = bus.data_wen;
  assign bus_sat.data_addr  = bus.data_addr;
  assign bus_sat.data_wdata = bus.data_wdata;
  assign bus_sat.sram_rdata = bus.sram_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference schedule: cycle of the pending/last issue cycle and who owns it (1 = data, 2 = inst).
  int          m_acc;
  int          m_who;
  int          m_conf;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_wdata;
  logic        e_d_ok, e_i_ok;

  logic        d_pend, i_pend;
  logic [3:0]  d_wen;
  logic [31:0] d_addr, d_wdata, i_addr;
  logic        rd_fix;
  logic [31:0] rd_val;

  int ok_who[$];
  int ok_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] exp_phys(input logic [31:0] a);
`ifdef KSEG_ADDR_MAP_EN
    if (a >= 32'h8000_0000) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  task automatic model_reset();
    m_acc  = -10;
    m_who  = 0;
    m_conf = 0;
    m_wen  = '0;
    m_addr = '0;
    m_wdata = '0;
    e_d_ok = 1'b0;
    e_i_ok = 1'b0;
  endtask

  task automatic apply();
    bus.data_req   = d_pend;
    bus.data_wen   = d_wen;
    bus.data_addr  = d_addr;
    bus.data_wdata = d_wdata;
    bus.inst_req   = i_pend;
    bus.inst_addr  = i_addr;
    bus.sram_rdata = rd_fix ? rd_val : $urandom;
  endtask

  // Requesters drop req the cycle after their ok, then may re-present with new fields.
  task automatic drive_rand(input int pd, input int pi);
    if (d_pend && e_d_ok) d_pend = 1'b0;
    if (i_pend && e_i_ok) i_pend = 1'b0;
    if (!d_pend && $urandom_range(0, 99) < pd) begin
      d_pend  = 1'b1;
      d_wen   = $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    if (!i_pend && $urandom_range(0, 99) < pi) begin
      i_pend = 1'b1;
      i_addr = $urandom;
    end
    apply();
  endtask

  task automatic settle();
    logic        x_en;
    logic [3:0]  x_wen;
    logic [31:0] x_addr, x_wdata;
    int          sat16, sat2;
    #1;
    if (m_acc == cyc) begin
      x_en = 1'b1; x_wen = m_wen; x_addr = m_addr; x_wdata = m_wdata;
    end else begin
      x_en = 1'b0; x_wen = '0; x_addr = '0; x_wdata = '0;
    end
    e_d_ok = (m_acc + 1 == cyc) && (m_who == 1);
    e_i_ok = (m_acc + 1 == cyc) && (m_who == 2);
    sat16 = m_conf > 65535 ? 65535 : m_conf;
    sat2  = m_conf > 3 ? 3 : m_conf;
    check_eq("sram_en",    64'(bus.sram_en),    64'(x_en));
    check_eq("sram_wen",   64'(bus.sram_wen),   64'(x_wen));
    check_eq("sram_addr",  64'(bus.sram_addr),  64'(x_addr));
    check_eq("sram_wdata", 64'(bus.sram_wdata), 64'(x_wdata));
    check_eq("inst_ok",    64'(bus.inst_ok),    64'(e_i_ok));
    check_eq("inst_rdata", 64'(bus.inst_rdata), e_i_ok ? 64'(bus.sram_rdata) : 64'(0));
    check_eq("data_ok",    64'(bus.data_ok),    64'(e_d_ok));
    check_eq("data_rdata", 64'(bus.data_rdata), e_d_ok ? 64'(bus.sram_rdata) : 64'(0));
    check_eq("inst_stall", 64'(bus.inst_stall), 64'(bus.inst_req & ~e_i_ok));
    check_eq("data_stall", 64'(bus.data_stall), 64'(bus.data_req & ~e_d_ok));
    check_eq("cnt16",      64'(cnt16),          64'(sat16));
    check_eq("cnt2",       64'(cnt2),           64'(sat2));
    if (bus.data_ok === 1'b1) begin ok_who.push_back(1); ok_cyc.push_back(cyc); end
    if (bus.inst_ok === 1'b1) begin ok_who.push_back(2); ok_cyc.push_back(cyc); end
  endtask

  task automatic grant(input int who);
    m_acc = cyc + 1;
    m_who = who;
    if (who == 1) begin
      m_wen = bus.data_wen; m_addr = exp_phys(bus.data_addr); m_wdata = bus.data_wdata;
    end else begin
      m_wen = '0; m_addr = exp_phys(bus.inst_addr); m_wdata = '0;
    end
  endtask

  // Port is busy in an issue cycle; in a response cycle only the other requester may be granted.
  task automatic decide();
    if (m_acc == cyc) begin
    end else if (m_acc + 1 == cyc) begin
      if (m_who == 1 && bus.inst_req)      grant(2);
      else if (m_who == 2 && bus.data_req) grant(1);
    end else begin
      if (bus.data_req && bus.inst_req) m_conf++;
      if (bus.data_req)      grant(1);
      else if (bus.inst_req) grant(2);
    end
  endtask

  task automatic advance();
    decide();
    @(negedge clk);
    cyc++;
  endtask

  task automatic cycle_begin(input int pd, input int pi);
    drive_rand(pd, pi);
    settle();
  endtask

  task automatic run(input int n, input int pd, input int pi);
    for (int k = 0; k < n; k++) begin
      cycle_begin(pd, pi);
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    model_reset();
    resetn = 1'b0;
    d_pend = 1'b0; i_pend = 1'b0;
    d_wen = '0; d_addr = '0; d_wdata = '0; i_addr = '0;
    rd_fix = 1'b1; rd_val = '0;
    apply();

    // Reset values; stalls follow req even in reset.
    #2;
    bus.data_req = 1'b1;
    #1;
    check_eq("rst_sram_en",    64'(bus.sram_en),    64'(0));
    check_eq("rst_sram_wen",   64'(bus.sram_wen),   64'(0));
    check_eq("rst_sram_addr",  64'(bus.sram_addr),  64'(0));
    check_eq("rst_sram_wdata", 64'(bus.sram_wdata), 64'(0));
    check_eq("rst_inst_ok",    64'(bus.inst_ok),    64'(0));
    check_eq("rst_data_ok",    64'(bus.data_ok),    64'(0));
    check_eq("rst_inst_rdata", 64'(bus.inst_rdata), 64'(0));
    check_eq("rst_data_rdata", 64'(bus.data_rdata), 64'(0));
    check_eq("rst_cnt16",      64'(cnt16),          64'(0));
    check_eq("rst_data_stall", 64'(bus.data_stall), 64'(1));
    check_eq("rst_inst_stall", 64'(bus.inst_stall), 64'(0));
    bus.data_req = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run(2, 0, 0);

    // Lone fetch.
    i_pend = 1'b1; i_addr = 32'h0000_1000; rd_val = 32'h2408_0001;
    cycle_begin(0, 0);
    check_eq("fetch_T_stall", 64'(bus.inst_stall), 64'(1));
    advance();
    cycle_begin(0, 0);
    check_eq("fetch_T1_en",   64'(bus.sram_en),    64'(1));
    check_eq("fetch_T1_addr", 64'(bus.sram_addr),  64'(32'h0000_1000));
    advance();
    cycle_begin(0, 0);
    check_eq("fetch_T2_ok",    64'(bus.inst_ok),    64'(1));
    check_eq("fetch_T2_rdata", 64'(bus.inst_rdata), 64'(32'h2408_0001));
    advance();
    run(2, 0, 0);

`ifdef KSEG_ADDR_MAP_EN
    i_pend = 1'b1; i_addr = 32'hBFC0_0000;
    cycle_begin(0, 0); advance();
    cycle_begin(0, 0);
    check_eq("kseg_fetch_addr", 64'(bus.sram_addr), 64'(32'h1FC0_0000));
    advance();
    run(3, 0, 0);
`endif

    // Store.
    d_pend = 1'b1; d_wen = 4'b0100; d_addr = 32'h8000_0012; d_wdata = 32'h5A5A_5A5A;
    cycle_begin(0, 0); advance();
    cycle_begin(0, 0);
    check_eq("store_wen",   64'(bus.sram_wen),   64'(4'b0100));
    check_eq("store_wdata", 64'(bus.sram_wdata), 64'(32'h5A5A_5A5A));
`ifdef KSEG_ADDR_MAP_EN
    check_eq("store_addr",  64'(bus.sram_addr),  64'(32'h0000_0012));
`else
    check_eq("store_addr",  64'(bus.sram_addr),  64'(32'h8000_0012));
`endif
    advance();
    cycle_begin(0, 0);
    check_eq("store_ok", 64'(bus.data_ok), 64'(1));
    advance();
    run(2, 0, 0);

    // Load stall window with a fixed read value present on every cycle.
    d_pend = 1'b1; d_wen = 4'h0; d_addr = 32'h0000_0100; rd_val = 32'hDEAD_BEEF;
    cycle_begin(0, 0);
    check_eq("stall_T",       64'(bus.data_stall), 64'(1));
    check_eq("stall_T_rdata", 64'(bus.data_rdata), 64'(0));
    advance();
    cycle_begin(0, 0);
    check_eq("stall_T1",       64'(bus.data_stall), 64'(1));
    check_eq("stall_T1_rdata", 64'(bus.data_rdata), 64'(0));
    advance();
    cycle_begin(0, 0);
    check_eq("stall_T2",       64'(bus.data_stall), 64'(0));
    check_eq("stall_T2_ok",    64'(bus.data_ok),    64'(1));
    check_eq("stall_T2_rdata", 64'(bus.data_rdata), 64'(32'hDEAD_BEEF));
    advance();
    cycle_begin(0, 0);
    check_eq("stall_T3_rdata", 64'(bus.data_rdata), 64'(0));
    advance();
    run(1, 0, 0);

    // Asynchronous reset during the data issue cycle.
    d_pend = 1'b1; d_wen = 4'hF; d_addr = 32'h0000_0040; d_wdata = 32'h1234_5678;
    cycle_begin(0, 0); advance();
    cycle_begin(0, 0);
    check_eq("mid_pre_en", 64'(bus.sram_en), 64'(1));
    resetn = 1'b0;
    #1;
    check_eq("mid_sram_en",    64'(bus.sram_en),    64'(0));
    check_eq("mid_sram_wen",   64'(bus.sram_wen),   64'(0));
    check_eq("mid_sram_addr",  64'(bus.sram_addr),  64'(0));
    check_eq("mid_sram_wdata", 64'(bus.sram_wdata), 64'(0));
    check_eq("mid_data_ok",    64'(bus.data_ok),    64'(0));
    check_eq("mid_inst_ok",    64'(bus.inst_ok),    64'(0));
    d_pend = 1'b0;
    apply();
    model_reset();
    @(negedge clk);
    cyc++;
    resetn = 1'b1;
    i_pend = 1'b1; i_addr = 32'h0000_2000;
    run(5, 0, 0);

    // Contention: both streaming from IDLE.
    rd_fix = 1'b0;
    ok_who.delete(); ok_cyc.delete();
    d_pend = 1'b1; d_wen = 4'h0; d_addr = 32'h0000_0300;
    i_pend = 1'b1; i_addr = 32'h0000_3000;
    t0 = cyc;
    run(9, 100, 100);
    run(8, 0, 0);
    check_eq("cont_count", 64'(ok_who.size() >= 4), 64'(1));
    for (int k = 0; k < 4; k++) begin
      if (k < ok_who.size()) begin
        check_eq($sformatf("cont_who%0d", k), 64'(ok_who[k]), 64'((k % 2 == 0) ? 1 : 2));
        check_eq($sformatf("cont_cyc%0d", k), 64'(ok_cyc[k] - t0), 64'(2 + 2 * k));
      end
    end
    check_eq("cont_cnt16", 64'(cnt16), 64'(1));

    // Saturation of the narrow counter.
    for (int r = 0; r < 5; r++) begin
      d_pend = 1'b1; d_wen = 4'h0; d_addr = $urandom;
      i_pend = 1'b1; i_addr = $urandom;
      run(6, 0, 0);
      if (r == 1) check_eq("sat_cnt2_early", 64'(cnt2), 64'(3));
    end
    check_eq("sat_cnt2",  64'(cnt2),  64'(3));
    check_eq("sat_cnt16", 64'(cnt16), 64'(6));

    // Randomized traffic at several load mixes.
    run(400, 30, 30);
    run(400, 80, 80);
    run(300, 100, 10);
    run(300, 10, 100);
    run(400, 50, 50);
    run(12, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single SRAM-style memory port between the instruction-fetch requester and the data (memory-stage) requester. It sequences each access through an issue cycle and a response cycle, and gives data accesses priority with forced alternation. It generates per-requester stall signals for the pipeline control and counts arbitration conflicts. It sits between the CPU core (IF and MEM stages) and the external sram bus of the SoC top.

## Interface
- ADDR_W, 32, address width of both requesters and the SRAM port
- DATA_W, 32, data width; the byte-enable width is DATA_W/8
- CNT_W, 16, width of the conflict counter
- clk  in  1  system clock; all state changes on the rising edge
- resetn  in  1  reset, asynchronous and active-low
- inst_req  in  1  fetch request; held with inst_addr stable until inst_ok
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetch data; valid only while inst_ok=1, otherwise 0
- inst_ok  out  1  single-cycle completion pulse
- inst_stall  out  1  inst_req & ~inst_ok, combinational
- data_req  in  1  data request; held with the fields below stable until data_ok
- data_wen  in  DATA_W/8  byte write enables; 0 means read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data, already lane-replicated by the MEM stage
- data_rdata  out  DATA_W  load data; valid only while data_ok=1, otherwise 0
- data_ok  out  1  single-cycle completion pulse, for reads and writes
- data_stall  out  1  data_req & ~data_ok, combinational
- sram_en  out  1  SRAM enable, registered
- sram_wen  out  DATA_W/8  SRAM byte write enables, registered
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_wdata  out  DATA_W  SRAM write data, registered
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en
- conflict_cnt  out  CNT_W  saturating count of lost instruction arbitrations

## Operation
- The FSM has five states: IDLE, D_ACC, D_RSP, I_ACC, I_RSP.
- IDLE:
  - data_req=1 → D_ACC; data wins ties.
  - Otherwise inst_req=1 → I_ACC.
  - Otherwise stay in IDLE.
- Entering x_ACC registers the requester's fields onto the sram_* outputs and sets sram_en=1.
  - For instruction accesses, sram_wen=0 and sram_wdata=0.
- x_ACC → x_RSP unconditionally. sram_* outputs return to 0 in x_RSP.
- x_RSP:
  - x_ok=1 and x_rdata=sram_rdata, combinational from the input.
  - Next state: if the *other* requester's req=1, go to its ACC state. Otherwise go to IDLE.
  - The just-served requester is never re-granted from RSP. Its req is still high during RSP by protocol, so it cannot be mistaken for a new request.
- Alternation follows from the RSP rule: with both requesters streaming, grants alternate D, I, D, I.
- conflict_cnt increments in every IDLE cycle with inst_req=1 and data_req=1. It saturates at 2^CNT_W−1.
- No alignment checking or byte-lane generation is done here. data_wen passes through unchanged.
- Asynchronous reset mid-operation:
  - State goes to IDLE immediately, and all outputs drop to 0.
  - Any in-flight SRAM read is discarded. Requesters re-present after reset.

## Timing
- Reset values: state IDLE; sram_en, sram_wen, sram_addr, sram_wdata, inst_ok, data_ok, inst_rdata, data_rdata and conflict_cnt all 0.
  - inst_stall and data_stall follow their req inputs.
- Latency: a request sampled at the edge ending IDLE cycle T gives sram_en=1 in T+1 and x_ok=1 in T+2.
- The requester drops or changes its req in T+3.
- Throughput:
  - A single requester gets one access per 3 cycles (RSP → IDLE → ACC).
  - Alternating requesters get one access per 2 cycles.
- Simultaneous new requests in IDLE: data is granted, inst stalls, and conflict_cnt increments once per such cycle.

## Configuration
- KSEG_ADDR_MAP_EN, when defined: any address with bit ADDR_W−1 = 1 is driven on sram_addr as {3'b000, addr[ADDR_W−4:0]}.
  - This applies to both requesters.
  - It is the kseg0/kseg1 → physical mapping.
- When undefined, sram_addr equals the requester address unchanged.

## Test plan
- Reset mid-access: assert resetn=0 during D_ACC → all sram_* outputs and both ok signals are 0 the same cycle, and the state is IDLE.
- Lone fetch: inst_req=1, inst_addr=0x0000_1000, SRAM returns 0x2408_0001 → sram_en=1 in T+1, inst_ok=1 with inst_rdata=0x2408_0001 in T+2.
  - With the macro defined, inst_addr=0xBFC0_0000 → sram_addr=0x1FC0_0000.
- Store: data_req=1, data_wen=4'b0100, data_addr=0x8000_0012, data_wdata=0x5A5A_5A5A → sram_wen=4'b0100 and sram_wdata=0x5A5A_5A5A in T+1, data_ok=1 in T+2.
  - sram_addr=0x0000_0012 with the macro defined, 0x8000_0012 without.
- Contention: inst_req and data_req both held high from IDLE → grant order D, I, D, I with ok pulses every 2 cycles.
  - conflict_cnt=1 after the first IDLE cycle and does not increase further while streaming.
- Saturation: with CNT_W=2, produce 5 IDLE conflict cycles → conflict_cnt stops at 3.
- Stall: data_req=1 with sram_rdata=0xDEAD_BEEF → data_stall=1 in T and T+1, 0 in T+2 where data_ok=1 and data_rdata=0xDEAD_BEEF; data_rdata=0 in all other cycles.
